ysyx_22050612_wbu: RTL and testbench
====================================

# ysyx_22050612_wbu

Writeback unit between the execute stage and the register file write port. It merges single-cycle ALU results with long-latency results (load / mul / div) into the single `wdata`/`waddr`/`wen` port. Long results are buffered in a 2-entry FIFO. A per-register busy scoreboard stalls issue on RAW and WAW hazards against outstanding long operations.

## Interface
Parameters:
- `ADDR_WIDTH`, default 5: register index width; the scoreboard holds 2**ADDR_WIDTH bits.
- `DATA_WIDTH`, default 64: register data width.
- `MAX_PEND`, default 4: maximum outstanding long operations (range 1..15).

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `iss_valid` in 1: decode presents an instruction.
- `iss_rs1` in ADDR_WIDTH: source 1 index.
- `iss_rs2` in ADDR_WIDTH: source 2 index.
- `iss_rd` in ADDR_WIDTH: destination index.
- `iss_long` in 1: instruction completes through the long-result path.
- `iss_ready` out 1: instruction may issue this cycle.
- `alu_valid` in 1: ALU result valid this cycle.
- `alu_rd` in ADDR_WIDTH: ALU destination.
- `alu_data` in DATA_WIDTH: ALU result.
- `lr_valid` in 1: long result offered.
- `lr_rd` in ADDR_WIDTH: long result destination.
- `lr_data` in DATA_WIDTH: long result data.
- `lr_ready` out 1: long result accepted when `lr_valid & lr_ready`.
- `rf_wen` out 1: register file write enable.
- `rf_waddr` out ADDR_WIDTH: register file write index.
- `rf_wdata` out DATA_WIDTH: register file write data.
- `err` out 1: sticky protocol error flag.

## Operation
- **State**
  - `busy[2**ADDR_WIDTH]`.
  - 2-entry FIFO of {rd, data} with count 0..2.
  - `pend` counter 0..MAX_PEND.
  - `err`.
- **Issue rule**
  - `iss_ready` = !rst & !busy[rs1] & !busy[rs2] & !busy[rd] & !(iss_long & pend==MAX_PEND).
  - `busy[0]` always reads 0.
- **Issue effects** (on `iss_valid & iss_ready & iss_long`)
  - `pend` increments.
  - If rd!=0, `busy[rd]` is set.
- **Push**
  - `lr_ready` = !rst & (count<2).
  - `lr_valid & lr_ready` writes {lr_rd, lr_data} at the FIFO tail.
  - There is no pass-through: a push never writes the register file in the same cycle.
- **Write arbitration**, per cycle, combinational:
  - ALU wins if `alu_valid & alu_rd!=0`: rf_wen=1, waddr=alu_rd, wdata=alu_data.
  - Else, if count>0, the FIFO head pops: rf_wen = (head.rd!=0), waddr=head.rd, wdata=head.data.
  - An rd=0 head still pops (drop), without asserting rf_wen.
  - Otherwise rf_wen=0, and waddr/wdata are 0.
- **Pop effects**
  - `pend` decrements.
  - `busy[head.rd]` clears.
  - Count decrements, unless a push happens in the same cycle.
- **Simultaneous events**
  - Issue-set and pop-clear on the same cycle: `pend` is unchanged.
  - Set and clear on the same register cannot coincide, because issue requires rd not busy.
  - Push and pop on the same cycle: count is unchanged and FIFO order is preserved.
- **Error conditions**
  - `err` sets on a push with `pend==0`.
  - `err` sets on a push with lr_rd!=0 & !busy[lr_rd].
  - `err` clears only on `rst`.
  - Erroneous data is still accepted.
- **Reset values**
  - busy=0, count=0, pend=0, err=0.
  - iss_ready=0, lr_ready=0, rf_wen=0, rf_waddr=0, rf_wdata=0.

## Timing
- ALU path: 0-cycle latency; the write is committed by the register file at the next posedge.
- Long path: a result accepted at edge N is written at the earliest during cycle N+1, and is delayed for every cycle that has an ALU write with rd!=0.
- A busy clear becomes visible to `iss_ready` the cycle after the pop. There is no bypass, so a dependent instruction stalls at least 1 cycle past the write.
- `lr_ready` is derived from the registered count only. When full, it stays 0 even if a pop occurs in the same cycle.
- `rst` asserted mid-operation discards the FIFO contents, the scoreboard and `pend` at that edge. Upstream must also flush.

## Test plan
- Reset with arbitrary stimulus, then release -> all outputs 0 during reset. The cycle after release: iss_ready=1 (no hazard), lr_ready=1.
- ALU write alu_rd=5, data 0x1234 -> same cycle rf_wen=1, waddr=5, wdata=0x1234. alu_rd=0 -> rf_wen=0.
- Issue long rd=7, then issue rs1=7 -> iss_ready=0. lr push rd=7 data 0xAA with no ALU activity -> next cycle rf_wen=1, waddr=7. iss_ready=1 one cycle later.
- Hold alu_valid rd=3 continuously while pushing 3 long results -> lr_ready=0 after 2 accepted, no long writes occur. Drop alu_valid -> the results are written in order, one per cycle, and lr_ready returns to 1.
- Issue MAX_PEND=4 long ops to rd 1..4, then a 5th long op to rd=9 -> iss_ready=0. A non-long op with rs1=rs2=rd=9 -> iss_ready=1.
- lr push rd=6 with no pending op -> err=1, and err remains 1 until rst.

Source files
------------

// File: rtl/ysyx_22050612_wbu_if.sv
//============================================================================
// Module : ysyx_22050612_wbu_if
// Brief  : Issue, ALU, long-result and register-file write signals of the WBU
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

interface ysyx_22050612_wbu_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64
);
  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rs1;
  logic [ADDR_WIDTH-1:0] iss_rs2;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic                  iss_long;
  logic                  iss_ready;
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  lr_valid;
  logic [ADDR_WIDTH-1:0] lr_rd;
  logic [DATA_WIDTH-1:0] lr_data;
  logic                  lr_ready;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_waddr;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  err;

  // master is the pipeline side, slave is the writeback unit
  modport master (
    output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_long,
    output alu_valid, alu_rd, alu_data,
    output lr_valid, lr_rd, lr_data,
    input  iss_ready, lr_ready, rf_wen, rf_waddr, rf_wdata, err
  );

  modport slave (
    input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_long,
    input  alu_valid, alu_rd, alu_data,
    input  lr_valid, lr_rd, lr_data,
    output iss_ready, lr_ready, rf_wen, rf_waddr, rf_wdata, err
  );
endinterface

`default_nettype wire

// File: rtl/ysyx_22050612_wbu.sv
//============================================================================
// Module : ysyx_22050612_wbu
// Brief  : Writeback merge of ALU and buffered long results with RAW/WAW
//          busy scoreboard
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module ysyx_22050612_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 64,
  parameter int MAX_PEND   = 4
) (
  input  logic                clk,
  input  logic                rst,
  ysyx_22050612_wbu_if.slave  wb
);

  localparam int       c_nreg     = 2 ** ADDR_WIDTH;
  localparam bit [3:0] c_max_pend = 4'(MAX_PEND);

  logic [c_nreg-1:0]     r_busy;
  logic [ADDR_WIDTH-1:0] r_fifo_rd   [2];
  logic [DATA_WIDTH-1:0] r_fifo_data [2];
  logic                  r_head;
  logic [1:0]            r_count;
  logic [3:0]            r_pend;
  logic                  r_err;

  logic [c_nreg-1:0]     w_busy_rd;
  logic                  w_issue;
  logic                  w_push;
  logic                  w_alu;
  logic                  w_pop;
  logic                  w_dec;
  logic                  w_tail;
  logic                  w_bad_push;
  logic [ADDR_WIDTH-1:0] w_head_rd;
  logic [c_nreg-1:0]     w_set;
  logic [c_nreg-1:0]     w_clr;

  // x0 is never a hazard regardless of what the scoreboard holds
  assign w_busy_rd = {r_busy[c_nreg-1:1], 1'b0};

  assign wb.iss_ready = !rst
                      & !w_busy_rd[wb.iss_rs1]
                      & !w_busy_rd[wb.iss_rs2]
                      & !w_busy_rd[wb.iss_rd]
                      & !(wb.iss_long & (r_pend == c_max_pend));
  assign wb.lr_ready  = !rst & (r_count != 2'd2);
  assign wb.err       = r_err;

  assign w_issue    = wb.iss_valid & wb.iss_ready & wb.iss_long;
  assign w_push     = wb.lr_valid & wb.lr_ready;
  assign w_alu      = !rst & wb.alu_valid & (wb.alu_rd != '0);
  assign w_pop      = !rst & !w_alu & (r_count != 2'd0);
  assign w_dec      = w_pop & (r_pend != 4'd0);
  assign w_head_rd  = r_fifo_rd[r_head];
  assign w_tail     = r_head ^ r_count[0];
  assign w_set      = (w_issue && (wb.iss_rd != '0)) ? (c_nreg'(1) << wb.iss_rd) : '0;
  assign w_clr      = w_pop ? (c_nreg'(1) << w_head_rd) : '0;
  assign w_bad_push = w_push & ((r_pend == 4'd0) | ((wb.lr_rd != '0) & !r_busy[wb.lr_rd]));

  always_comb begin
    wb.rf_wen   = 1'b0;
    wb.rf_waddr = '0;
    wb.rf_wdata = '0;
    if (w_alu) begin
      wb.rf_wen   = 1'b1;
      wb.rf_waddr = wb.alu_rd;
      wb.rf_wdata = wb.alu_data;
    end else if (w_pop) begin
      // an rd=0 head is dropped without a write
      wb.rf_wen   = (w_head_rd != '0);
      wb.rf_waddr = w_head_rd;
      wb.rf_wdata = r_fifo_data[r_head];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy  <= '0;
      r_head  <= 1'b0;
      r_count <= 2'd0;
      r_pend  <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_busy  <= (r_busy | w_set) & ~w_clr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_pend  <= r_pend + 4'(w_issue) - 4'(w_dec);
      if (w_pop) begin
        r_head <= ~r_head;
      end
      if (w_bad_push) begin
        r_err <= 1'b1;
      end
    end
  end

  // payload storage needs no reset; count qualifies every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_rd[w_tail]   <= wb.lr_rd;
      r_fifo_data[w_tail] <= wb.lr_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22050612_wbu.sv
//============================================================================
// Module : tb_ysyx_22050612_wbu
// Brief  : Directed and random checks of the WBU against a queue-based model
// Rev    : 1.0  initial release
//============================================================================
`default_nettype none

module tb_ysyx_22050612_wbu;

  localparam int c_max_pend = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [63:0] d;
  } ent_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_mis;

  ysyx_22050612_wbu_if bus ();

  ysyx_22050612_wbu #(
    .ADDR_WIDTH (5),
    .DATA_WIDTH (64),
    .MAX_PEND   (c_max_pend)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  bit [31:0]  m_busy;
  ent_t       m_q[$];
  int         m_pend;
  bit         m_err;
  bit         last_push;
  bit         last_iss;
  logic [4:0] outq[$];
  int         sel_idx;

  // observations of the most recent cycle
  logic       obs_irdy, obs_lrr, obs_wen, obs_err;
  logic [4:0] obs_wa;
  logic [63:0] obs_wd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit mb(input logic [4:0] r);
    return (r != 5'd0) && m_busy[r];
  endfunction

  task automatic idle();
    bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0; bus.iss_long = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.lr_valid  = 1'b0; bus.lr_rd = '0; bus.lr_data = '0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd, input logic lng);
    bus.iss_valid = 1'b1; bus.iss_rs1 = rs1; bus.iss_rs2 = rs2; bus.iss_rd = rd; bus.iss_long = lng;
  endtask

  // one clock: compare outputs against the model, then advance the model
  task automatic cycle();
    bit          e_ir, e_lr, e_wen, pop, push, iss;
    logic [4:0]  e_wa;
    logic [63:0] e_wd;
    ent_t        h;
    #1;
    e_ir = !rst && !mb(bus.iss_rs1) && !mb(bus.iss_rs2) && !mb(bus.iss_rd)
           && !(bus.iss_long && m_pend == c_max_pend);
    e_lr = !rst && (m_q.size() < 2);
    e_wen = 1'b0; e_wa = '0; e_wd = '0; pop = 1'b0;
    h.rd = '0; h.d = '0;
    if (!rst) begin
      if (bus.alu_valid && bus.alu_rd != 5'd0) begin
        e_wen = 1'b1; e_wa = bus.alu_rd; e_wd = bus.alu_data;
      end else if (m_q.size() > 0) begin
        pop = 1'b1; h = m_q[0];
        e_wen = (h.rd != 5'd0); e_wa = h.rd; e_wd = h.d;
      end
    end
    push = bus.lr_valid && e_lr;
    iss  = bus.iss_valid && e_ir && bus.iss_long;
    chk("iss_ready", 64'(bus.iss_ready), 64'(e_ir));
    chk("lr_ready",  64'(bus.lr_ready),  64'(e_lr));
    chk("rf_wen",    64'(bus.rf_wen),    64'(e_wen));
    chk("rf_waddr",  64'(bus.rf_waddr),  64'(e_wa));
    chk("rf_wdata",  bus.rf_wdata,       e_wd);
    chk("err",       64'(bus.err),       64'(m_err));
    obs_irdy = bus.iss_ready; obs_lrr = bus.lr_ready; obs_wen = bus.rf_wen;
    obs_wa = bus.rf_waddr; obs_wd = bus.rf_wdata; obs_err = bus.err;
    last_push = push; last_iss = iss;
    @(posedge clk);
    if (rst) begin
      m_busy = '0; m_q.delete(); m_pend = 0; m_err = 1'b0;
    end else begin
      if (push && (m_pend == 0 || (bus.lr_rd != 5'd0 && !m_busy[bus.lr_rd]))) m_err = 1'b1;
      if (pop) begin
        void'(m_q.pop_front());
        m_busy[h.rd] = 1'b0;
        if (m_pend > 0) m_pend--;
      end
      if (iss) begin
        m_pend++;
        if (bus.iss_rd != 5'd0) m_busy[bus.iss_rd] = 1'b1;
      end
      if (push) m_q.push_back('{bus.lr_rd, bus.lr_data});
    end
    @(negedge clk);
  endtask

  task automatic push_lr(input logic [4:0] rd, input logic [63:0] d);
    bit done;
    done = 1'b0;
    bus.lr_valid = 1'b1; bus.lr_rd = rd; bus.lr_data = d;
    for (int i = 0; i < 10 && !done; i++) begin
      cycle();
      done = last_push;
    end
    if (!done) chk("push_timeout", 64'(0), 64'(1));
    bus.lr_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_mis = 0;
    m_busy = '0; m_pend = 0; m_err = 1'b0;
    rst = 1'b1;
    idle();
    @(negedge clk);

    // reset with arbitrary stimulus: everything must read zero
    for (int i = 0; i < 4; i++) begin
      issue(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom));
      bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'hdead;
      bus.lr_valid = 1'b1; bus.lr_rd = 5'd3; bus.lr_data = 64'hbeef;
      cycle();
    end
    chk("rst_wen", 64'(obs_wen), 64'(0));
    chk("rst_irdy", 64'(obs_irdy), 64'(0));
    rst = 1'b0;
    idle();
    cycle();
    chk("rel_irdy", 64'(obs_irdy), 64'(1));
    chk("rel_lrr", 64'(obs_lrr), 64'(1));

    // ALU writes
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 64'h1234;
    cycle();
    chk("alu5_waddr", 64'(obs_wa), 64'd5);
    chk("alu5_wdata", obs_wd, 64'h1234);
    bus.alu_rd = 5'd0;
    cycle();
    chk("alu0_wen", 64'(obs_wen), 64'(0));
    idle();

    // RAW stall on an outstanding long op
    issue(5'd0, 5'd0, 5'd7, 1'b1);
    cycle();
    issue(5'd7, 5'd0, 5'd1, 1'b0);
    cycle();
    chk("raw_stall", 64'(obs_irdy), 64'(0));
    idle();
    push_lr(5'd7, 64'hAA);
    issue(5'd7, 5'd0, 5'd1, 1'b0);
    cycle();
    chk("lr7_waddr", 64'(obs_wa), 64'd7);
    chk("lr7_wen", 64'(obs_wen), 64'(1));
    cycle();
    chk("raw_release", 64'(obs_irdy), 64'(1));
    idle();

    // ALU holds the port while long results back up
    for (int r = 10; r <= 12; r++) begin
      issue(5'd0, 5'd0, 5'(r), 1'b1);
      cycle();
    end
    idle();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 64'h33;
    push_lr(5'd10, 64'h100);
    push_lr(5'd11, 64'h101);
    bus.lr_valid = 1'b1; bus.lr_rd = 5'd12; bus.lr_data = 64'h102;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("full_lrr", 64'(obs_lrr), 64'(0));
      chk("hold_waddr", 64'(obs_wa), 64'd3);
    end
    bus.alu_valid = 1'b0;
    cycle();
    chk("drain0", 64'(obs_wa), 64'd10);
    cycle();
    chk("drain1", 64'(obs_wa), 64'd11);
    idle();
    cycle();
    chk("drain2", 64'(obs_wa), 64'd12);
    cycle();
    chk("drain_lrr", 64'(obs_lrr), 64'(1));

    // pending limit
    for (int r = 1; r <= 4; r++) begin
      issue(5'd0, 5'd0, 5'(r), 1'b1);
      cycle();
    end
    issue(5'd0, 5'd0, 5'd9, 1'b1);
    cycle();
    chk("pend_full", 64'(obs_irdy), 64'(0));
    issue(5'd9, 5'd9, 5'd9, 1'b0);
    cycle();
    chk("pend_short", 64'(obs_irdy), 64'(1));
    idle();
    for (int r = 1; r <= 4; r++) push_lr(5'(r), 64'(r * 16));
    cycle();
    cycle();

    // push with nothing pending is sticky until reset
    push_lr(5'd6, 64'h66);
    for (int i = 0; i < 3; i++) cycle();
    chk("err_sticky", 64'(obs_err), 64'(1));
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    cycle();
    chk("err_clear", 64'(obs_err), 64'(0));

    // random traffic; upstream returns results only for issued long ops
    outq.delete();
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      idle();
      if ($urandom_range(0, 1) == 1)
        issue(5'($urandom), 5'($urandom), 5'($urandom), ($urandom_range(0, 9) < 4));
      if ($urandom_range(0, 9) < 3) begin
        bus.alu_valid = 1'b1; bus.alu_rd = 5'($urandom); bus.alu_data = {$urandom, $urandom};
      end
      sel_idx = -1;
      if (outq.size() > 0 && $urandom_range(0, 9) < 6) begin
        sel_idx = $urandom_range(0, outq.size() - 1);
        bus.lr_valid = 1'b1; bus.lr_rd = outq[sel_idx]; bus.lr_data = {$urandom, $urandom};
      end else if ($urandom_range(0, 99) < 3) begin
        bus.lr_valid = 1'b1; bus.lr_rd = 5'($urandom); bus.lr_data = {$urandom, $urandom};
      end
      cycle();
      if (rst) begin
        outq.delete();
      end else begin
        if (last_push && sel_idx >= 0) outq.delete(sel_idx);
        if (last_iss) outq.push_back(bus.iss_rd);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
